// File: rtl/mac_result_serializer_if.sv
// Output stream of the MAC result serializer: one bw-bit word per valid/ready handshake.
// A word transfers on a rising clk edge where out_valid && out_ready; while out_valid is high and
// out_ready is low the producer holds out_data/out_last stable, and out_valid never depends on out_ready.
interface mac_result_serializer_if #(
  parameter int bw = 8
);
  logic [bw-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/mac_result_serializer.sv
// Drain side of the SIMD MAC array: snapshots the packed lane vector on start and streams
// the lanes (or only the chained reduction lane) out over a valid/ready link.
module mac_result_serializer #(
  parameter int bw      = 8,
  parameter int num_MAC = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sel_last,
  input  logic [bw*num_MAC-1:0]  din,
  input  logic                   clr_err,
  output logic                   busy,
  output logic                   overrun,
  output logic                   dbg_state,
  mac_result_serializer_if.master m_if
);

  localparam int IDX_W = $clog2(num_MAC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_MAC - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [bw*num_MAC-1:0]  shadow_q, shadow_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [bw-1:0]          data_q, data_d;
  logic                   last_q, last_d;
  logic                   overrun_q, overrun_d;

  logic                   fire;
  logic                   accept;
  logic                   ovr_set;
  logic [IDX_W-1:0]       start_idx;
  logic [IDX_W-1:0]       idx_inc;

  function automatic logic [bw-1:0] lane_of(input logic [bw*num_MAC-1:0] v,
                                            input logic [IDX_W-1:0]      i);
    lane_of = v[int'(i)*bw +: bw];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    data_d    = data_q;
    last_d    = last_q;
    overrun_d = overrun_q;
    accept    = 1'b0;
    ovr_set   = 1'b0;

    fire      = (state_q == ST_SEND) && m_if.out_ready;
    start_idx = sel_last ? LAST_IDX : '0;
    idx_inc   = idx_q + IDX_W'(1);

    case (state_q)
      ST_IDLE: begin
        accept = start;
      end
      ST_SEND: begin
        if (fire && last_q) begin
          // A start coinciding with the final handshake chains straight into the next frame.
          accept = start;
          if (!start) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end
        end else begin
          ovr_set = start;
          if (fire) begin
            idx_d  = idx_inc;
            data_d = lane_of(shadow_q, idx_inc);
            last_d = (idx_inc == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      state_d  = ST_SEND;
      shadow_d = din;
      idx_d    = start_idx;
      data_d   = lane_of(din, start_idx);
      last_d   = (start_idx == LAST_IDX);
    end

    // A new overrun event takes priority over a simultaneous clear.
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end
  end

  assign m_if.out_data  = data_q;
  assign m_if.out_last  = last_q;
  assign m_if.out_valid = (state_q == ST_SEND);
  assign busy           = (state_q == ST_SEND);
  assign overrun        = overrun_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mac_result_serializer.sv
// Directed bench for mac_result_serializer: scoreboard of {last,data} words filled when a
// frame is started and drained by a negedge monitor that also checks the hold rule.
module tb_mac_result_serializer;

  localparam int BW = 8;
  localparam int N  = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic            sel_last;
  logic [BW*N-1:0] din;
  logic            clr_err;
  logic            busy;
  logic            overrun;
  logic            dbg_state;

  mac_result_serializer_if #(.bw(BW)) s_if ();

  mac_result_serializer #(.bw(BW), .num_MAC(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sel_last  (sel_last),
    .din       (din),
    .clr_err   (clr_err),
    .busy      (busy),
    .overrun   (overrun),
    .dbg_state (dbg_state),
    .m_if      (s_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [BW:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        held_valid;
  logic [BW:0] held_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [BW*N-1:0] v, input logic sl);
    logic lst;
    if (sl) begin
      exp_q.push_back({1'b1, v[(N-1)*BW +: BW]});
    end else begin
      for (int i = 0; i < N; i++) begin
        lst = (i == N - 1);
        exp_q.push_back({lst, v[i*BW +: BW]});
      end
    end
  endtask

  // scoreboard side: pops on every accepted word, checks held words while stalled
  task automatic monitor();
    logic [BW:0] w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        held_valid = 1'b0;
      end else begin
        if (held_valid && s_if.out_valid)
          check("hold", {23'd0, s_if.out_last, s_if.out_data}, {23'd0, held_word});
        if (s_if.out_valid && s_if.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_word: observed %0h expected none", {s_if.out_last, s_if.out_data});
          end else begin
            w = exp_q.pop_front();
            check("word", {23'd0, s_if.out_last, s_if.out_data}, {23'd0, w});
          end
          held_valid = 1'b0;
        end else if (s_if.out_valid) begin
          held_valid = 1'b1;
          held_word  = {s_if.out_last, s_if.out_data};
        end
      end
    end
  endtask

  // driver: one-cycle start strobe, then scramble din/sel_last to prove they are not resampled
  task automatic start_frame(input logic [BW*N-1:0] v, input logic sl);
    logic [BW-1:0] first;
    first    = sl ? v[(N-1)*BW +: BW] : v[BW-1:0];
    din      = v;
    sel_last = sl;
    start    = 1'b1;
    push_frame(v, sl);
    @(posedge clk); #1;
    start    = 1'b0;
    din      = {8{$urandom()}};
    sel_last = ~sl;
    check("first_valid", {31'd0, s_if.out_valid}, 32'd1);
    check("first_busy",  {31'd0, busy}, 32'd1);
    check("first_data",  {24'd0, s_if.out_data}, {24'd0, first});
    check("first_last",  {31'd0, s_if.out_last}, {31'd0, sl});
  endtask

  // driver: run until scoreboard empties; mode 1 toggles ready 1,0,1,0; optional start pulse
  task automatic drain(input int mode, input int pulse_at, input logic [BW*N-1:0] pulse_din,
                       input logic pulse_push, input int exp_cycles, input string tag);
    int cycles;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 400) begin
      s_if.out_ready = (mode == 1) ? (cycles % 2 == 0) : 1'b1;
      if (cycles == pulse_at) begin
        start    = 1'b1;
        din      = pulse_din;
        sel_last = 1'b0;
        if (pulse_push) push_frame(pulse_din, 1'b0);
      end
      @(posedge clk); #1;
      if (start) begin
        start = 1'b0;
        if (pulse_push) begin
          check({tag, "_b2b_valid"},   {31'd0, s_if.out_valid}, 32'd1);
          check({tag, "_b2b_data"},    {24'd0, s_if.out_data}, {24'd0, pulse_din[BW-1:0]});
          check({tag, "_b2b_overrun"}, {31'd0, overrun}, 32'd0);
        end
      end
      cycles++;
    end
    check({tag, "_cycles"}, cycles, exp_cycles);
    check({tag, "_busy_after"},  {31'd0, busy}, 32'd0);
    check({tag, "_valid_after"}, {31'd0, s_if.out_valid}, 32'd0);
    exp_q.delete();
  endtask

  logic [BW*N-1:0] v1, v3, v4, v5, v6, v7;

  initial begin
    rst            = 1'b0;
    start          = 1'b0;
    sel_last       = 1'b0;
    clr_err        = 1'b0;
    din            = '0;
    s_if.out_ready = 1'b0;
    held_valid     = 1'b0;
    held_word      = '0;
    fork
      monitor();
    join_none

    for (int i = 0; i < N; i++) begin
      v1[i*BW +: BW] = 8'(i + 1);
      v3[i*BW +: BW] = 8'($urandom_range(0, 255));
      v4[i*BW +: BW] = 8'($urandom_range(0, 255));
      v5[i*BW +: BW] = 8'($urandom_range(0, 255));
      v6[i*BW +: BW] = 8'($urandom_range(0, 255));
      v7[i*BW +: BW] = 8'(8'hC0 + i);
    end
    v3[(N-1)*BW +: BW] = 8'hA5;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",   {31'd0, s_if.out_valid}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_data",    {24'd0, s_if.out_data}, 32'd0);
    check("rst_last",    {31'd0, s_if.out_last}, 32'd0);
    check("rst_state",   {31'd0, dbg_state}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // full frame at full throughput: 32 words in 32 cycles
    start_frame(v1, 1'b0);
    drain(0, -1, '0, 1'b0, 32, "t1");

    // ready toggling 1,0,1,0: 32 words need 63 ready-phases after the first word appears
    start_frame(v1, 1'b0);
    drain(1, -1, '0, 1'b0, 63, "t2");

    // single-word dump of the reduction lane
    start_frame(v3, 1'b1);
    drain(0, -1, '0, 1'b0, 1, "t3");

    // start mid-frame is ignored but flags overrun
    start_frame(v4, 1'b0);
    drain(0, 10, {8{$urandom()}}, 1'b0, 32, "t4");
    check("t4_overrun_set", {31'd0, overrun}, 32'd1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("t4_overrun_clr", {31'd0, overrun}, 32'd0);

    // set beats clear in the same cycle, while stalled
    start_frame(v1, 1'b0);
    s_if.out_ready = 1'b0;
    start   = 1'b1;
    clr_err = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    clr_err = 1'b0;
    check("t4b_set_wins", {31'd0, overrun}, 32'd1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("t4b_cleared", {31'd0, overrun}, 32'd0);
    drain(0, -1, '0, 1'b0, 32, "t4b");

    // back-to-back frame: start coincides with the final handshake
    start_frame(v5, 1'b0);
    drain(0, 31, {N{8'h55}}, 1'b1, 64, "t5");
    check("t5_overrun", {31'd0, overrun}, 32'd0);

    // asynchronous reset mid-frame while stalled on word 5
    start_frame(v6, 1'b0);
    s_if.out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    s_if.out_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("t6_valid", {31'd0, s_if.out_valid}, 32'd0);
    check("t6_busy",  {31'd0, busy}, 32'd0);
    check("t6_data",  {24'd0, s_if.out_data}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_frame(v7, 1'b0);
    drain(0, -1, '0, 1'b0, 32, "t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
